// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: Basys3 servo defaults, counter-width helpers and the shared clamp/scale function
package servo_pwm_pkg;
  localparam int DEF_CLK_PER_TICK = 100;
  localparam int DEF_PERIOD = 20000;
  localparam int DEF_PULSE_MIN = 1000;
  localparam int DEF_PULSE_MAX = 2000;
  function automatic int cnt_w(input int period);
    return $clog2(period + 1);
  endfunction
  function automatic int pre_w(input int clk_per_tick);
    return $clog2(clk_per_tick + 1);
  endfunction
  function automatic int unsigned scale_width(input int unsigned v, input int unsigned in_min,
      input int unsigned in_max, input int unsigned pulse_min, input int unsigned pulse_max,
      input int unsigned in_w);
    int unsigned c;
    longint unsigned p;
    c = v < in_min ? in_min : v > in_max ? in_max : v;
    p = 64'(c - in_min) * 64'(pulse_max - pulse_min);
    return pulse_min + 32'(p >> in_w);
  endfunction
endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one axis (clk, rst, wrap, frame_cnt, val, en -> pwm) doing clamp, scale, slew, enable latch and compare
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int IN_W = 10,
  parameter int FRAME_W = 15,
  parameter int IN_MIN = 0,
  parameter int IN_MAX = 1023,
  parameter int PULSE_MIN = DEF_PULSE_MIN,
  parameter int PULSE_MAX = DEF_PULSE_MAX,
  parameter int SLEW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrap,
  input  logic [FRAME_W-1:0] frame_cnt,
  input  logic [IN_W-1:0]    val,
  input  logic               en,
  output logic               pwm
);
  localparam logic [FRAME_W-1:0] W_RST = FRAME_W'((PULSE_MIN + PULSE_MAX) / 2);
  localparam logic [FRAME_W-1:0] STEP = FRAME_W'(SLEW);
  logic [FRAME_W-1:0] width, target, next_width;
  logic en_q;
  always_comb begin
    target = FRAME_W'(scale_width(32'(val), IN_MIN, IN_MAX, PULSE_MIN, PULSE_MAX, IN_W));
    next_width = SLEW == 0 ? target
               : target > width ? (target - width > STEP ? width + STEP : target)
               : (width - target > STEP ? width - STEP : target);
  end
  always_ff @(posedge clk)
    if (rst) begin
      width <= W_RST;
      en_q <= 1'b0;
      pwm <= 1'b0;
    end else begin
      if (wrap) begin
        width <= next_width;
        en_q <= en;
      end
      pwm <= en_q && frame_cnt < width;
    end
endmodule

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: N_CH servo PWM outputs (clk, rst, val, en -> pwm, frame_start) from one shared prescaler and frame counter
module servo_pwm_array
  import servo_pwm_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int IN_W = 10,
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
  parameter int PERIOD = DEF_PERIOD,
  parameter int PULSE_MIN = DEF_PULSE_MIN,
  parameter int PULSE_MAX = DEF_PULSE_MAX,
  parameter int IN_MIN = 0,
  parameter int IN_MAX = 2**IN_W - 1,
  parameter int SLEW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*IN_W-1:0] val,
  input  logic [N_CH-1:0]      en,
  output logic [N_CH-1:0]      pwm,
  output logic                 frame_start
);
  localparam int FRAME_W = cnt_w(PERIOD);
  localparam int TICK_W = pre_w(CLK_PER_TICK);
  if (IN_MIN >= IN_MAX || PULSE_MIN >= PULSE_MAX || PULSE_MAX > PERIOD) begin : g_bad_cfg
    $error("servo_pwm_array: IN_MIN/IN_MAX, PULSE_MIN/PULSE_MAX or PERIOD out of range");
  end
  logic [TICK_W-1:0] pre;
  logic [FRAME_W-1:0] frame_cnt;
  logic tick, wrap, wrap_q;
  always_comb begin
    tick = pre == TICK_W'(CLK_PER_TICK - 1);
    wrap = tick && frame_cnt == FRAME_W'(PERIOD - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      pre <= '0;
      frame_cnt <= '0;
      wrap_q <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      frame_cnt <= wrap ? '0 : tick ? frame_cnt + 1'b1 : frame_cnt;
      wrap_q <= wrap;
      frame_start <= wrap_q;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .IN_W(IN_W), .FRAME_W(FRAME_W), .IN_MIN(IN_MIN), .IN_MAX(IN_MAX),
      .PULSE_MIN(PULSE_MIN), .PULSE_MAX(PULSE_MAX), .SLEW(SLEW)
    ) u_ch (
      .clk(clk), .rst(rst), .wrap(wrap), .frame_cnt(frame_cnt),
      .val(val[i*IN_W +: IN_W]), .en(en[i]), .pwm(pwm[i])
    );
  end
endmodule

// File: tb/tb_servo_pwm_array.sv
// tb_servo_pwm_array: scoreboard bench for two servo_pwm_array configurations sharing one stimulus stream
module tb_servo_pwm_array;
  localparam int CPT = 2, PER = 40, PMIN = 10, PMAX = 20, FRAME = CPT * PER;
  typedef struct { int hi[2]; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [19:0] val = '0;
  logic [1:0] en = '0;
  logic [1:0] pwm0, pwm1, mp;
  logic fs0, fs1, mf;
  int imin [2] = '{0, 200};
  int imax [2] = '{1023, 800};
  int slw [2] = '{0, 2};
  int mw [2][2];
  exp_t q [2][$];
  exp_t me;
  int checks = 0, failures = 0, cyc = 0;
  int gap [2], fs_cnt [2], hi [2][2];
  logic lowseen [2][2], bad [2][2];
  always #5 clk = ~clk;
  servo_pwm_array #(.N_CH(2), .IN_W(10), .CLK_PER_TICK(CPT), .PERIOD(PER),
    .PULSE_MIN(PMIN), .PULSE_MAX(PMAX)) dut0 (
    .clk(clk), .rst(rst), .val(val), .en(en), .pwm(pwm0), .frame_start(fs0));
  servo_pwm_array #(.N_CH(2), .IN_W(10), .CLK_PER_TICK(CPT), .PERIOD(PER),
    .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .IN_MIN(200), .IN_MAX(800), .SLEW(2)) dut1 (
    .clk(clk), .rst(rst), .val(val), .en(en), .pwm(pwm1), .frame_start(fs1));
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  task automatic check(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask
  function automatic int target(input int d, input int v);
    int c;
    c = v < imin[d] ? imin[d] : (v > imax[d] ? imax[d] : v);
    return PMIN + ((c - imin[d]) * (PMAX - PMIN)) / 1024;
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) mw[d][c] = (PMIN + PMAX) / 2;
      q[d].delete();
    end
  endtask
  task automatic model_wrap();
    exp_t e;
    int t, dl;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        t = target(d, int'(val[c*10 +: 10]));
        dl = t - mw[d][c];
        if (slw[d] != 0 && dl > slw[d]) dl = slw[d];
        if (slw[d] != 0 && dl < -slw[d]) dl = -slw[d];
        mw[d][c] = mw[d][c] + dl;
        e.hi[c] = en[c] ? mw[d][c] * CPT : 0;
      end
      q[d].push_back(e);
    end
  endtask
  task automatic run_frame(input int v0, input int v1, input logic [1:0] e, input int o);
    repeat (o) @(negedge clk);
    val = {10'(v1), 10'(v0)};
    en = e;
    model_wrap();
    repeat (FRAME - o) @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      mp = d == 0 ? pwm0 : pwm1;
      mf = d == 0 ? fs0 : fs1;
      if (rst) begin
        check("reset_outputs", d, int'({mf, mp}), 0);
        gap[d] = 0;
        fs_cnt[d] = 0;
        for (int c = 0; c < 2; c++) begin
          hi[d][c] = 0;
          lowseen[d][c] = 1'b0;
          bad[d][c] = 1'b0;
        end
      end else begin
        gap[d]++;
        if (mf) begin
          fs_cnt[d]++;
          if (fs_cnt[d] == 1) begin
            check("first_frame_len", d, gap[d], FRAME + 1);
            for (int c = 0; c < 2; c++) check("dark_first_frame", d, hi[d][c], 0);
          end else begin
            check("frame_len", d, gap[d], FRAME);
            check("scoreboard_nonempty", d, int'(q[d].size() > 0), 1);
            if (q[d].size() > 0) begin
              me = q[d].pop_front();
              for (int c = 0; c < 2; c++) begin
                check(c == 0 ? "pulse_clk_ch0" : "pulse_clk_ch1", d, hi[d][c], me.hi[c]);
                check("pulse_contiguous", d, int'(bad[d][c]), 0);
              end
            end
          end
          gap[d] = 0;
          for (int c = 0; c < 2; c++) begin
            hi[d][c] = 0;
            lowseen[d][c] = 1'b0;
            bad[d][c] = 1'b0;
          end
        end
        for (int c = 0; c < 2; c++)
          if (mp[c]) begin
            hi[d][c]++;
            if (lowseen[d][c]) bad[d][c] = 1'b1;
          end else lowseen[d][c] = 1'b1;
      end
    end
  end
  int dv0 [7] = '{512, 0, 100, 1023, 1023, 1023, 0};
  int dv1 [7] = '{512, 1023, 900, 0, 0, 0, 1023};
  logic [1:0] den [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01};
  int doff [7] = '{40, 79, 0, 20, 10, 5, 79};
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_frame(dv0[i], dv1[i], den[i], doff[i]);
    for (int i = 0; i < 30; i++)
      run_frame($urandom_range(0, 1023), $urandom_range(0, 1023), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0 ? 79 : $urandom_range(0, 79));
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frame(512, 512, 2'b11, 30);
    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(0, 1023), $urandom_range(0, 1023), 2'($urandom_range(0, 3)),
                $urandom_range(0, 79));
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) check("frame_start_count", d, fs_cnt[d], 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
